// File: rtl/coin_pkg.sv
// +----------------------------------------------------------------------------+
// | Package : coin_pkg                                                         |
// | Coin values and vend-sequencer state encoding, shared by coin-slot blocks. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package coin_pkg;

    localparam int DIME_CENTS    = 10;
    localparam int NICKEL_CENTS  = 5;
    localparam int QUARTER_CENTS = 25;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2,
        REFUND = 2'd3
    } vend_state_t;

endpackage

`default_nettype wire

// File: rtl/vend_credit_controller.sv
// +----------------------------------------------------------------------------+
// | Module : vend_credit_controller                                            |
// | Accumulates coin credit, strobes vend at price, pays change in nickels.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module vend_credit_controller
    import coin_pkg::*;
#(
    parameter int PRICE      = 65,
    parameter int MAX_CREDIT = 95,
    parameter int CREDIT_W   = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dimeDetected,
    input  logic                nickelDetected,
    input  logic                quarterDetected,
    input  logic                cancel,
    input  logic                dispenserReady,
    output logic [CREDIT_W-1:0] credit,
    output logic                vend,
    output logic                changeNickel,
    output logic                coinReturn,
    output logic                busy
);

    localparam logic [CREDIT_W:0]   c_max_ext   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W:0]   c_price_ext = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] c_price     = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] c_nickel    = CREDIT_W'(NICKEL_CENTS);

    vend_state_t         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                coin_return_q, coin_return_d;

    logic [1:0]          w_coin_count;
    logic [CREDIT_W:0]   w_coin_value;
    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W-1:0] w_after_vend;
    logic                w_paying;

    assign w_coin_count = {1'b0, dimeDetected} + {1'b0, nickelDetected} + {1'b0, quarterDetected};

    always_comb begin
        w_coin_value = '0;
        if (dimeDetected)    w_coin_value = (CREDIT_W+1)'(DIME_CENTS);
        if (nickelDetected)  w_coin_value = (CREDIT_W+1)'(NICKEL_CENTS);
        if (quarterDetected) w_coin_value = (CREDIT_W+1)'(QUARTER_CENTS);
    end

    // One extra bit so a sum above the ceiling cannot wrap back into range.
    assign w_sum        = {1'b0, credit_q} + w_coin_value;
    assign w_after_vend = credit_q - c_price;
    assign w_paying     = (state_q == CHANGE) || (state_q == REFUND);

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        coin_return_d = (w_coin_count > 2'd1) || ((w_coin_count != 2'd0) && (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (w_coin_count == 2'd1) begin
                    if (w_sum > c_max_ext) begin
                        coin_return_d = 1'b1;
                    end else begin
                        credit_d = w_sum[CREDIT_W-1:0];
                        if (w_sum >= c_price_ext) state_d = VEND;
                    end
                end else if ((w_coin_count == 2'd0) && cancel && (credit_q != '0)) begin
                    state_d = REFUND;
                end
            end
            VEND: begin
                credit_d = w_after_vend;
                state_d  = (w_after_vend == '0) ? IDLE : CHANGE;
            end
            CHANGE, REFUND: begin
                if (dispenserReady) begin
                    credit_d = credit_q - c_nickel;
                    if (credit_q == c_nickel) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            coin_return_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            coin_return_q <= coin_return_d;
        end
    end

    assign credit       = credit_q;
    assign vend         = (state_q == VEND);
    assign changeNickel = w_paying && dispenserReady;
    assign coinReturn   = coin_return_q;
    assign busy         = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_vend_credit_controller.sv
// +----------------------------------------------------------------------------+
// | Module : tb_vend_credit_controller                                         |
// | Drives a PRICE=65 and a PRICE=95 instance in lockstep against a model.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_vend_credit_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, dime, nickel, quarter, cancel, ready;
    logic [6:0] credit_a, credit_b;
    logic vend_a, vend_b, cn_a, cn_b, ret_a, ret_b, busy_a, busy_b;

    vend_credit_controller dut_a (
        .clk(clk), .reset(reset), .dimeDetected(dime), .nickelDetected(nickel),
        .quarterDetected(quarter), .cancel(cancel), .dispenserReady(ready),
        .credit(credit_a), .vend(vend_a), .changeNickel(cn_a),
        .coinReturn(ret_a), .busy(busy_a)
    );

    vend_credit_controller #(.PRICE(95), .MAX_CREDIT(95), .CREDIT_W(7)) dut_b (
        .clk(clk), .reset(reset), .dimeDetected(dime), .nickelDetected(nickel),
        .quarterDetected(quarter), .cancel(cancel), .dispenserReady(ready),
        .credit(credit_b), .vend(vend_b), .changeNickel(cn_b),
        .coinReturn(ret_b), .busy(busy_b)
    );

    int checks = 0;
    int errors = 0;

    // Model: mode 0 = waiting for coins, 1 = vending, 2 = paying out nickels.
    int  price [2];
    int  m_credit [2];
    int  m_mode [2];
    bit  m_ret [2];
    logic [10:0] obs_vec [2];
    logic [10:0] exp_vec [2];

    // Stimulus word: {dime, nickel, quarter, cancel, ready}
    localparam logic [4:0] IDL0 = 5'b00000, IDL1 = 5'b00001;
    localparam logic [4:0] QTR1 = 5'b00101, QTR0 = 5'b00100;
    localparam logic [4:0] DIM1 = 5'b10001, NIK1 = 5'b01001;
    localparam logic [4:0] CAN0 = 5'b00010, DN1  = 5'b11001;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_credit[k] = 0;
            m_mode[k]   = 0;
            m_ret[k]    = 1'b0;
        end
    endtask

    task automatic model_step(input logic [4:0] s);
        for (int k = 0; k < 2; k++) begin
            int cnt;
            int val;
            bit ret;
            cnt = int'(s[4]) + int'(s[3]) + int'(s[2]);
            val = 10 * int'(s[4]) + 5 * int'(s[3]) + 25 * int'(s[2]);
            ret = (cnt > 1) || (cnt == 1 && m_mode[k] != 0);
            if (m_mode[k] == 0) begin
                if (cnt == 1) begin
                    if (m_credit[k] + val > 95) ret = 1'b1;
                    else begin
                        m_credit[k] += val;
                        if (m_credit[k] >= price[k]) m_mode[k] = 1;
                    end
                end else if (cnt == 0 && s[1] && m_credit[k] > 0) begin
                    m_mode[k] = 2;
                end
            end else if (m_mode[k] == 1) begin
                m_credit[k] -= price[k];
                m_mode[k] = (m_credit[k] == 0) ? 0 : 2;
            end else if (s[0]) begin
                m_credit[k] -= 5;
                if (m_credit[k] == 0) m_mode[k] = 0;
            end
            m_ret[k] = ret;
        end
    endtask

    // Applies one cycle of inputs, captures outputs mid-cycle, then advances the model.
    task automatic cycle(input logic [4:0] s);
        {dime, nickel, quarter, cancel, ready} = s;
        @(negedge clk);
        obs_vec[0] = {credit_a, vend_a, cn_a, ret_a, busy_a};
        obs_vec[1] = {credit_b, vend_b, cn_b, ret_b, busy_b};
        for (int k = 0; k < 2; k++)
            exp_vec[k] = {7'(m_credit[k]), m_mode[k] == 1, (m_mode[k] == 2) && s[0],
                          m_ret[k], m_mode[k] != 0};
        @(posedge clk);
        model_step(s);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {dime, nickel, quarter, cancel, ready} = 5'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        cycle(IDL1);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_vec[k] !== 11'd0) begin
                errors++;
                $display("FAIL reset dut%0d: got credit=%0d flags(vend,nickel,ret,busy)=%b, expected credit=0 flags=0000",
                         k, obs_vec[k][10:4], obs_vec[k][3:0]);
            end
        end
    endtask

    task automatic test_vend_change();
        logic [4:0] seq [7] = '{QTR1, QTR1, QTR1, IDL1, IDL1, IDL1, IDL1};
        int nickels = 0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cycle(seq[i]);
            nickels += int'(obs_vec[0][2]);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_vec[k] !== exp_vec[k]) begin
                    errors++;
                    $display("FAIL vend_change step%0d dut%0d: got credit=%0d flags=%b, expected credit=%0d flags=%b",
                             i, k, obs_vec[k][10:4], obs_vec[k][3:0], exp_vec[k][10:4], exp_vec[k][3:0]);
                end
            end
            if (i == 3) begin
                checks++;
                if (obs_vec[0][10:3] !== {7'd75, 1'b1}) begin
                    errors++;
                    $display("FAIL vend_change_vend: got credit=%0d vend=%b, expected credit=75 vend=1",
                             obs_vec[0][10:4], obs_vec[0][3]);
                end
            end
        end
        checks++;
        if (nickels != 2 || obs_vec[0] !== 11'd0) begin
            errors++;
            $display("FAIL vend_change_payout: got nickels=%0d final=%b, expected nickels=2 final=0", nickels, obs_vec[0]);
        end
    endtask

    task automatic test_exact_price();
        logic [4:0] seq [7] = '{QTR1, QTR1, DIM1, NIK1, IDL1, IDL1, IDL1};
        int nickels = 0;
        int vends = 0;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cycle(seq[i]);
            nickels += int'(obs_vec[0][2]);
            vends   += int'(obs_vec[0][3]);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_vec[k] !== exp_vec[k]) begin
                    errors++;
                    $display("FAIL exact_price step%0d dut%0d: got credit=%0d flags=%b, expected credit=%0d flags=%b",
                             i, k, obs_vec[k][10:4], obs_vec[k][3:0], exp_vec[k][10:4], exp_vec[k][3:0]);
                end
            end
        end
        checks++;
        if (nickels != 0 || vends != 1 || obs_vec[0] !== 11'd0) begin
            errors++;
            $display("FAIL exact_price_summary: got vends=%0d nickels=%0d final=%b, expected vends=1 nickels=0 final=0",
                     vends, nickels, obs_vec[0]);
        end
    endtask

    task automatic test_refund();
        logic [4:0] seq [9] = '{DIM1, NIK1, CAN0, IDL1, IDL0, IDL1, IDL0, IDL1, IDL1};
        int nickels = 0;
        int misaligned = 0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(seq[i]);
            if (i < 8) nickels += int'(obs_vec[0][2]);
            if (obs_vec[0][2] && !seq[i][0]) misaligned++;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_vec[k] !== exp_vec[k]) begin
                    errors++;
                    $display("FAIL refund step%0d dut%0d: got credit=%0d flags=%b, expected credit=%0d flags=%b",
                             i, k, obs_vec[k][10:4], obs_vec[k][3:0], exp_vec[k][10:4], exp_vec[k][3:0]);
                end
            end
        end
        checks++;
        if (nickels != 3 || misaligned != 0 || obs_vec[0][10:4] !== 7'd0) begin
            errors++;
            $display("FAIL refund_summary: got nickels=%0d misaligned=%0d credit=%0d, expected 3, 0, 0",
                     nickels, misaligned, obs_vec[0][10:4]);
        end
    endtask

    task automatic test_overflow_reject();
        logic [4:0] seq [7] = '{QTR1, QTR1, QTR1, QTR1, DIM1, NIK1, IDL1};
        logic [7:0] want [7] = '{8'd0, 8'd50, 8'd100, 8'd150, 8'd151, 8'd170, 8'd180};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cycle(seq[i]);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_vec[k] !== exp_vec[k]) begin
                    errors++;
                    $display("FAIL overflow step%0d dut%0d: got credit=%0d flags=%b, expected credit=%0d flags=%b",
                             i, k, obs_vec[k][10:4], obs_vec[k][3:0], exp_vec[k][10:4], exp_vec[k][3:0]);
                end
            end
            // Price-95 instance: {credit, coinReturn}
            checks++;
            if ({obs_vec[1][10:4], obs_vec[1][1]} !== want[i]) begin
                errors++;
                $display("FAIL overflow_p95 step%0d: got credit=%0d ret=%b, expected credit=%0d ret=%b",
                         i, obs_vec[1][10:4], obs_vec[1][1], want[i][7:1], want[i][0]);
            end
        end
    endtask

    task automatic test_illegal_coins();
        logic [4:0] seq [10] = '{QTR1, QTR1, QTR1, IDL1, QTR0, IDL0, IDL1, IDL1, DN1, IDL1};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(seq[i]);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_vec[k] !== exp_vec[k]) begin
                    errors++;
                    $display("FAIL illegal step%0d dut%0d: got credit=%0d flags=%b, expected credit=%0d flags=%b",
                             i, k, obs_vec[k][10:4], obs_vec[k][3:0], exp_vec[k][10:4], exp_vec[k][3:0]);
                end
            end
            if (i == 5 || i == 9) begin
                checks++;
                if ({obs_vec[0][10:4], obs_vec[0][1]} !== ((i == 5) ? {7'd10, 1'b1} : {7'd0, 1'b1})) begin
                    errors++;
                    $display("FAIL illegal_return step%0d: got credit=%0d ret=%b, expected credit=%0d ret=1",
                             i, obs_vec[0][10:4], obs_vec[0][1], (i == 5) ? 10 : 0);
                end
            end
        end
    endtask

    task automatic test_reset_mid_change();
        logic [4:0] seq [5] = '{QTR0, QTR0, QTR0, IDL0, IDL0};
        do_reset();
        for (int i = 0; i < 5; i++) cycle(seq[i]);
        checks++;
        if ({obs_vec[0][10:4], obs_vec[0][0]} !== {7'd10, 1'b1}) begin
            errors++;
            $display("FAIL mid_change_setup: got credit=%0d busy=%b, expected credit=10 busy=1",
                     obs_vec[0][10:4], obs_vec[0][0]);
        end
        do_reset();
        cycle(DIM1);
        checks++;
        if (obs_vec[0] !== 11'd0) begin
            errors++;
            $display("FAIL mid_change_reset: got credit=%0d flags=%b, expected credit=0 flags=0000",
                     obs_vec[0][10:4], obs_vec[0][3:0]);
        end
        cycle(IDL1);
        checks++;
        if (obs_vec[0] !== {7'd10, 4'b0000}) begin
            errors++;
            $display("FAIL mid_change_coin: got credit=%0d flags=%b, expected credit=10 flags=0000",
                     obs_vec[0][10:4], obs_vec[0][3:0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int p;
            logic [2:0] coins;
            p = int'($urandom_range(0, 19));
            if (p < 3)       coins = 3'b100;
            else if (p < 6)  coins = 3'b010;
            else if (p < 9)  coins = 3'b001;
            else if (p == 9) coins = 3'b101;
            else if (p == 10) coins = 3'b111;
            else             coins = 3'b000;
            if (i % 150 == 149) do_reset();
            cycle({coins, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0});
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_vec[k] !== exp_vec[k]) begin
                    errors++;
                    $display("FAIL random cyc%0d dut%0d: got credit=%0d flags=%b, expected credit=%0d flags=%b",
                             i, k, obs_vec[k][10:4], obs_vec[k][3:0], exp_vec[k][10:4], exp_vec[k][3:0]);
                end
            end
        end
    endtask

    initial begin
        price[0] = 65;
        price[1] = 95;
        reset = 1'b1;
        {dime, nickel, quarter, cancel, ready} = 5'b0;
        model_reset();
        test_reset();
        test_vend_change();
        test_exact_price();
        test_refund();
        test_overflow_reject();
        test_illegal_coins();
        test_reset_mid_change();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vend_credit_controller.md
# vend_credit_controller

Credit accumulator and vend sequencer that sits directly downstream of the coin detector in the coin-slot emulator. It consumes the detector's one-cycle dime/nickel/quarter pulses and accumulates credit in cents. When credit reaches the price, it issues a vend strobe and pays out change one nickel at a time through a ready-gated dispenser handshake. It also supports a cancel/refund path.

## Interface
Parameters:
- PRICE, 65: item price in cents; multiple of 5; 5 ≤ PRICE ≤ MAX_CREDIT.
- MAX_CREDIT, 95: credit ceiling in cents; multiple of 5; must be < 2**CREDIT_W.
- CREDIT_W, 7: width of the credit register.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- dimeDetected  in  1  one-cycle pulse from the coin detector.
- nickelDetected  in  1  one-cycle pulse from the coin detector.
- quarterDetected  in  1  one-cycle pulse from the coin detector.
- cancel  in  1  refund request; honoured only in IDLE with nonzero credit.
- dispenserReady  in  1  change dispenser can accept a nickel this cycle.
- credit  out  CREDIT_W  current credit in cents (registered).
- vend  out  1  one-cycle item-release strobe.
- changeNickel  out  1  dispense one nickel; high only when dispenserReady is also high.
- coinReturn  out  1  one-cycle pulse that diverts the just-detected coin to the return chute.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, VEND, CHANGE, REFUND.
- IDLE, exactly one detect pulse, value v (10/5/25):
  - If credit+v > MAX_CREDIT: the coin is rejected, coinReturn pulses, and credit is unchanged.
  - Otherwise credit ← credit+v. If the new credit ≥ PRICE, the next state is VEND; otherwise stay in IDLE.
- More than one detect input high in the same cycle, in any state: the input is illegal. coinReturn pulses and credit is unchanged.
- Any detect pulse while in VEND, CHANGE or REFUND: coinReturn pulses and credit is unchanged.
- VEND lasts exactly one cycle, with vend=1. At its end, credit ← credit−PRICE. The next state is CHANGE if the result is nonzero, otherwise IDLE.
- CHANGE and REFUND:
  - changeNickel = dispenserReady (a combinational AND with the state).
  - Each cycle with changeNickel=1 decrements credit by 5.
  - The block moves to IDLE on the edge where credit goes from 5 to 0.
  - If dispenserReady stays low, the block waits indefinitely; there is no timeout.
- IDLE with cancel=1 and credit>0: next state is REFUND. A coin pulse in the same cycle takes priority; cancel is ignored that cycle.
- cancel in any other state, or with credit=0, has no effect.
- Arithmetic: the sum is computed at CREDIT_W+1 bits for the overflow compare. Credit is always a multiple of 5 and never underflows.

## Timing
- Reset values: credit=0, state=IDLE, vend=0, changeNickel=0, coinReturn=0, busy=0.
- Reset mid-operation discards credit and pending change. Outputs are at reset values in the cycle after the reset edge.
- Coin pulse sampled at edge N:
  - credit shows the new value from cycle N+1.
  - vend is high during cycle N+1 if the price is reached.
  - The first changeNickel can occur in cycle N+2.
- coinReturn is registered: it is high in the cycle after the offending detect pulse, for exactly one cycle.
- Change payout takes (remainder/5) cycles when dispenserReady is held high.

## Structure
- Shared package coin_pkg holds:
  - constants DIME_CENTS=10, NICKEL_CENTS=5, QUARTER_CENTS=25;
  - the enum typedef vend_state_t {IDLE, VEND, CHANGE, REFUND}.
- The coin detector should import the same package in future revisions.
- Single module with no sub-module. Coin-value decode and the payout decrement are small enough to stay inline.

## Test plan
All scenarios use PRICE=65 and MAX_CREDIT=95 unless noted.
- Reset, then quarter ×3 with dispenserReady=1 → credit 25, 50, 75 → vend one cycle → credit 10 → changeNickel on 2 consecutive cycles → credit 0, busy=0.
- Quarter, quarter, dime, nickel → credit 65 → vend one cycle → credit 0 → IDLE directly, no changeNickel.
- Dime then nickel (credit 15), cancel=1, dispenserReady toggling 1,0,1,0,1 → exactly 3 changeNickel pulses, each aligned with a ready cycle → credit 0.
- With PRICE=95: three quarters (credit 75), then a quarter → coinReturn pulse, credit stays 75. Then a dime → 85; a nickel → 90.
- A quarter arriving during CHANGE, and a simultaneous dime+nickel pulse in IDLE → coinReturn for each, with credit unchanged in both cases.
- Reset asserted mid-CHANGE with credit 10 → next cycle credit=0, busy=0, changeNickel=0. A subsequent coin is accepted normally.
